// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch stage.
// Holds the fetch PC and issues one word read at a time to instruction memory
// using a req/ack handshake. The returned word is presented to decode with a
// valid/ready handshake. Redirects from pcSrc/C_offset are applied when decode
// accepts the held instruction. A HALT opcode stops fetching until reset.
module fetch_unit #(
    parameter int              AW       = 16,
    parameter int              IW       = 16,
    parameter logic [AW-1:0]   RESET_PC = '0,
    parameter logic [4:0]      HALT_OP  = 5'b11111
) (
    input  logic            CLK,
    input  logic            RST_N,
    output logic            imem_req,
    output logic [AW-1:0]   imem_addr,
    input  logic            imem_ack,
    input  logic [IW-1:0]   imem_rdata,
    output logic            instr_valid,
    input  logic            instr_ready,
    output logic [IW-1:0]   instr,
    output logic [4:0]      opcode,
    output logic [AW-1:0]   pc,
    input  logic            pcSrc,
    input  logic            C_offset,
    input  logic [AW-1:0]   target,
    output logic            halted
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_FETCH  = 2'b01,
        ST_HOLD   = 2'b10,
        ST_HALTED = 2'b11
    } state_t;

    localparam logic [AW-1:0] PC_ONE = {{(AW-1){1'b0}}, 1'b1};

    state_t          r_state;
    state_t          w_state_nxt;
    logic [AW-1:0]   r_fetch_pc;
    logic            r_imem_req;
    logic [IW-1:0]   r_instr;
    logic [AW-1:0]   r_pc;
    logic            r_instr_valid;
    logic            r_halted;

    logic            w_fetch_done;
    logic            w_accept;
    logic            w_is_halt;
    logic [AW-1:0]   w_next_pc;

    // Address of the next fetch after the held instruction is accepted.
    // All sums wrap modulo 2^AW; target is used as-is as a 2's-complement offset.
    function automatic logic [AW-1:0] next_fetch_pc(
        input logic [AW-1:0] cur_pc,
        input logic          redirect,
        input logic          relative,
        input logic [AW-1:0] tgt
    );
        logic [AW-1:0] result;
        if (!redirect) begin
            result = cur_pc + PC_ONE;
        end else if (!relative) begin
            result = tgt;
        end else begin
            result = cur_pc + PC_ONE + tgt;
        end
        return result;
    endfunction

    assign w_fetch_done = (r_state == ST_FETCH) && imem_ack;
    assign w_accept     = (r_state == ST_HOLD) && r_instr_valid && instr_ready;
    assign w_is_halt    = (r_instr[IW-1 -: 5] == HALT_OP);
    assign w_next_pc    = next_fetch_pc(r_pc, pcSrc, C_offset, target);

    // State register; reset abandons any outstanding read by returning to IDLE.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state decode: ack only matters in FETCH, ready only in HOLD.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                w_state_nxt = ST_FETCH;
            end
            ST_FETCH: begin
                if (imem_ack) begin
                    w_state_nxt = ST_HOLD;
                end else begin
                    w_state_nxt = ST_FETCH;
                end
            end
            ST_HOLD: begin
                if (w_accept) begin
                    if (w_is_halt) begin
                        w_state_nxt = ST_HALTED;
                    end else begin
                        w_state_nxt = ST_FETCH;
                    end
                end else begin
                    w_state_nxt = ST_HOLD;
                end
            end
            ST_HALTED: begin
                w_state_nxt = ST_HALTED;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Fetch datapath: request flag, fetch PC, captured instruction and halt flag.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_imem_req    <= 1'b0;
            r_fetch_pc    <= RESET_PC;
            r_instr       <= '0;
            r_pc          <= '0;
            r_instr_valid <= 1'b0;
            r_halted      <= 1'b0;
        end else begin
            // Registered from next state so req rises on entry to FETCH and a
            // 0-wait ack can be taken in that very cycle.
            r_imem_req <= (w_state_nxt == ST_FETCH);
            if (w_fetch_done) begin
                r_instr       <= imem_rdata;
                r_pc          <= r_fetch_pc;
                r_instr_valid <= 1'b1;
            end else if (w_accept) begin
                r_instr_valid <= 1'b0;
                if (w_is_halt) begin
                    // HALT wins over any redirect presented alongside it.
                    r_halted <= 1'b1;
                end else begin
                    r_fetch_pc <= w_next_pc;
                end
            end else begin
                r_instr_valid <= r_instr_valid;
            end
        end
    end

    assign imem_req    = r_imem_req;
    assign imem_addr   = r_fetch_pc;
    assign instr_valid = r_instr_valid;
    assign instr       = r_instr;
    assign opcode      = r_instr[IW-1 -: 5];
    assign pc          = r_pc;
    assign halted      = r_halted;

endmodule
